// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4 -- four-way round-robin arbiter feeding a 2-to-4 decoder stage.
//
// Grants one requester at a time and holds the grant until the owner releases
// it (done pulse or request drop). The search for the next owner starts at the
// requester after the previous owner, so every active requester is served in turn.
// Exactly one idle cycle separates consecutive grants.
//
// Optional feature, macro ARB_TIMEOUT_EN: an 8-bit hold counter forces a
// release after HOLD_MAX cycles of grant and pulses timeout for one cycle.
// Without the macro there is no counter and timeout is tied to 0.
//
// Parameters:
//   HOLD_MAX   maximum grant length in cycles (2..255), used with ARB_TIMEOUT_EN
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   req[3:0]   request lines, bit i = requester i
//   done       owner release pulse, ignored while no grant is active
//   grant_idx  index of the granted requester (decoder A), registered
//   grant_en   grant valid (decoder E), registered
//   busy       FSM is in GRANT; exposes the FSM state, equals grant_en
//   timeout    one-cycle pulse on a forced release
//
// Handshake: req[i] acts as valid and the grant as ready. An owner keeps its
// grant while req[i] stays high and done stays low; it gives the grant back by
// pulsing done or dropping req[i]. Other requests wait, with no preemption.
module rr_arbiter_4 #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] grant_idx,
  output logic       grant_en,
  output logic       busy,
  output logic       timeout
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("rr_arbiter_4: HOLD_MAX must be in 2..255");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] idx_nxt;
  logic       en_nxt;
  logic       timeout_nxt;
  logic [1:0] pick;
  logic       any_req;
  logic       expired;
  logic       release_c;

  // Rotating priority scan: first set request at ptr, ptr+1, ... mod 4.
  always_comb begin
    pick    = ptr;
    any_req = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        pick    = ptr + 2'(k);
        any_req = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt;

  // cnt is 0 on the first granted cycle, so HOLD_MAX-1 marks the last one.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (state == GRANT) begin
      cnt <= cnt + 8'd1;
    end else begin
      cnt <= 8'd0;
    end
  end

  assign expired = (state == GRANT) && (cnt == HOLD_LAST);
`else
  assign expired = 1'b0;
`endif

  assign release_c = done || !req[grant_idx] || expired;

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    idx_nxt     = grant_idx;
    en_nxt      = grant_en;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          idx_nxt   = pick;
          en_nxt    = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (release_c) begin
          en_nxt      = 1'b0;
          ptr_nxt     = grant_idx + 2'd1;
          state_nxt   = IDLE;
          // done has priority: a release that coincides with done is not forced.
          timeout_nxt = expired && !done;
        end
      end
      default: begin
        state_nxt = IDLE;
        en_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      grant_idx <= 2'd0;
      grant_en  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      grant_idx <= idx_nxt;
      grant_en  <= en_nxt;
      timeout   <= timeout_nxt;
    end
  end

  assign busy = (state == GRANT);

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4 -- directed bench for rr_arbiter_4 with hand-computed
// expectations. Built with HOLD_MAX=4; the timeout section expects a forced
// release when ARB_TIMEOUT_EN is defined and an indefinite hold otherwise.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] grant_idx;
  logic       grant_en;
  logic       busy;
  logic       timeout;

  int n_vec;
  int n_err;

  rr_arbiter_4 #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .grant_idx (grant_idx),
    .grant_en  (grant_en),
    .busy      (busy),
    .timeout   (timeout)
  );

  // Clock block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the full output set against one expected state.
  task automatic chk_out(input string tag, input logic en, input logic [1:0] idx,
                         input logic to);
    chk({tag, ".en"},   8'(grant_en), 8'(en));
    chk({tag, ".idx"},  8'(grant_idx), 8'(idx));
    chk({tag, ".busy"}, 8'(busy), 8'(en));
    chk({tag, ".to"},   8'(timeout), 8'(to));
  endtask

  initial begin
    logic [1:0] order [5];
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    n_vec = 0;
    n_err = 0;

    // Reset
    rst = 1'b1; req = 4'b0000; done = 1'b0;
    tick(); tick();
    chk_out("reset", 1'b0, 2'd0, 1'b0);
    rst = 1'b0;

    // Basic grant and release
    req = 4'b0101;
    tick(); chk_out("basic_g0", 1'b1, 2'd0, 1'b0);
    done = 1'b1;
    tick(); chk_out("basic_rel", 1'b0, 2'd0, 1'b0);
    done = 1'b0;
    tick(); chk_out("basic_g2", 1'b1, 2'd2, 1'b0);
    done = 1'b1;
    tick(); chk_out("basic_rel2", 1'b0, 2'd2, 1'b0);
    done = 1'b0;

    // Fairness from a fresh pointer
    rst = 1'b1; req = 4'b0000;
    tick(); chk_out("fair_rst", 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick(); chk_out($sformatf("fair_g%0d", i), 1'b1, order[i], 1'b0);
      done = 1'b1;
      tick(); chk_out($sformatf("fair_idle%0d", i), 1'b0, order[i], 1'b0);
      done = 1'b0;
    end

    // Request drop releases and moves the pointer past the owner
    req = 4'b1000;
    tick(); chk_out("drop_g3", 1'b1, 2'd3, 1'b0);
    req = 4'b0000;
    tick(); chk_out("drop_rel", 1'b0, 2'd3, 1'b0);
    req = 4'b1001;
    tick(); chk_out("drop_g0", 1'b1, 2'd0, 1'b0);
    req = 4'b0000;
    tick(); chk_out("drop_rel0", 1'b0, 2'd0, 1'b0);

    // Timeout (pointer now 1)
    req = 4'b0010;
    tick(); chk_out("to_g1", 1'b1, 2'd1, 1'b0);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick(); chk_out($sformatf("to_hold%0d", i), 1'b1, 2'd1, 1'b0);
    end
    tick(); chk_out("to_force", 1'b0, 2'd1, 1'b1);
    tick(); chk_out("to_regrant", 1'b1, 2'd1, 1'b0);
`else
    for (int i = 0; i < 6; i++) begin
      tick(); chk_out($sformatf("to_hold%0d", i), 1'b1, 2'd1, 1'b0);
    end
`endif
    done = 1'b1; req = 4'b0000;
    tick(); chk_out("to_rel", 1'b0, 2'd1, 1'b0);
    done = 1'b0;

    // Reset in the middle of a grant (pointer now 2)
    req = 4'b0100;
    tick(); chk_out("mid_g2", 1'b1, 2'd2, 1'b0);
    rst = 1'b1;
    tick(); chk_out("mid_rst", 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    tick(); chk_out("mid_regrant", 1'b1, 2'd2, 1'b0);
    req = 4'b0000;
    tick(); chk_out("mid_rel", 1'b0, 2'd2, 1'b0);

    // Spurious done in IDLE (pointer now 3)
    done = 1'b1;
    tick(); chk_out("spur_done", 1'b0, 2'd2, 1'b0);
    done = 1'b0;
    tick(); chk_out("spur_idle", 1'b0, 2'd2, 1'b0);
    req = 4'b0001;
    tick(); chk_out("spur_g0", 1'b1, 2'd0, 1'b0);

    // No preemption: a new request waits for the release
    req = 4'b0011;
    tick(); chk_out("nopre_hold", 1'b1, 2'd0, 1'b0);
    done = 1'b1;
    tick(); chk_out("nopre_rel", 1'b0, 2'd0, 1'b0);
    done = 1'b0;
    tick(); chk_out("nopre_g1", 1'b1, 2'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
